// File: rtl/paint_pkg.sv
// paint_pkg: shared types and screen constants for the paint pipeline.
package paint_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ROW_ADDR_W = 9;
  localparam int COORD_W = 11;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ROW_ADDR_W-1:0] row_addr_t;
  typedef logic [SCREEN_W-1:0] row_t;
endpackage

// File: rtl/frame_restore_if.sv
// frame_restore_if: per-pixel (x, y, colour) stream with valid/ready handshake.
//   master drives pix_x, pix_y, pix_color, pix_valid; slave drives pix_ready.
interface frame_restore_if;
  import paint_pkg::*;
  coord_t pix_x;
  coord_t pix_y;
  logic pix_color;
  logic pix_valid;
  logic pix_ready;
  modport master(output pix_x, pix_y, pix_color, pix_valid, input pix_ready);
  modport slave(input pix_x, pix_y, pix_color, pix_valid, output pix_ready);
endinterface

// File: rtl/frame_restore_rise.sv
// rise_detect: registered rising-edge detector for a level input.
//   CLOCK_50, reset_n (async active-low), d level in, rise one-cycle pulse out.
module rise_detect (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic prev;
  logic armed;
  // armed stays low until d has been seen low once, so a level held high
  // through reset release is not mistaken for a fresh edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= d;
      armed <= armed | ~d;
    end
  end
  assign rise = d & ~prev & armed;
endmodule

// File: rtl/frame_restore.sv
// frame_restore: streams the saved-frame row RAM out as per-pixel beats.
//   CLOCK_50/reset_n clock and async active-low reset; load_sw start level;
//   read_addr/read_data row RAM read port; pix pixel stream (master);
//   busy restore in progress; done one-cycle pulse after the last beat.
module frame_restore
  import paint_pkg::*;
#(
  parameter int WIDTH = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int ADDR_W = ROW_ADDR_W,
  parameter int RAM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              load_sw,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [WIDTH-1:0]  read_data,
  frame_restore_if.master   pix,
  output logic              busy,
  output logic              done
);
  localparam int XW = $clog2(WIDTH);
  localparam coord_t X_LAST = coord_t'(WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);
  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);
  state_t state, state_n;
  coord_t x, x_n, row, row_n;
  logic [1:0] cnt, cnt_n;
  logic [WIDTH-1:0] row_q;
  logic [ADDR_W-1:0] addr_q;
  logic start, cap;
  rise_detect u_rise (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .d(load_sw), .rise(start));
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x <= '0;
      row <= '0;
      cnt <= '0;
      row_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      x <= x_n;
      row <= row_n;
      cnt <= cnt_n;
      addr_q <= read_addr;
      if (cap) row_q <= read_data;
    end
  end
  always_comb begin
    state_n = state;
    x_n = x;
    row_n = row;
    cnt_n = '0;
    cap = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        row_n = '0;
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        cnt_n = cnt + 2'd1;
        if (cnt == LAT_LAST) begin
          cap = 1'b1;
          x_n = '0;
          state_n = EMIT;
        end
      end
      EMIT: if (pix.pix_ready) begin
        if (x != X_LAST) x_n = x + coord_t'(1);
        else if (row != Y_LAST) begin
          row_n = row + coord_t'(1);
          state_n = FETCH;
        end else state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // The address is presented only in FETCH and otherwise held, so each row is read once.
  assign read_addr = (state == FETCH) ? row[ADDR_W-1:0] : addr_q;
  assign pix.pix_valid = state == EMIT;
  assign pix.pix_x = x;
  assign pix.pix_y = row;
  assign pix.pix_color = row_q[x[XW-1:0]];
  assign busy = state inside {FETCH, WAIT, EMIT};
  assign done = state == DONE;
endmodule
